// File: rtl/rx_frame_receiver_pkg.sv
// Shared definitions for the 7-bit serial link: receiver FSM states, frame
// geometry and the even-parity rule used on both ends of the line.
package rx_frame_receiver_pkg;

    localparam int DATA_BITS  = 7;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PARITY    = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rx_frame_receiver.sv
// Deframes start, parity, 7 data bits (LSB first) and stop, one line bit per
// clk, and presents each word on a valid/ack holding register with status.
module rx_frame_receiver
    import rx_frame_receiver_pkg::*;
#(
    parameter logic START_SIG = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 s_in,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic IDLE_LVL = ~START_SIG;
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 load;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= S_IDLE;
        end else begin
            // NOTE: state and datapath registers use non-blocking assignments so
            // every flop samples pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_next = state;
        load       = 1'b0;
        unique case (state)
            S_IDLE:      if (s_in == START_SIG) state_next = S_PARITY;
            S_PARITY:    state_next = S_DATA;
            S_DATA:      if (bit_idx == LAST_IDX) state_next = S_STOP;
            S_STOP: begin
                load       = 1'b1;
                state_next = (s_in == IDLE_LVL) ? S_IDLE : S_WAIT_IDLE;
            end
            // A stuck-low line must return to idle before a new start is seen.
            S_WAIT_IDLE: if (s_in == IDLE_LVL) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == S_PARITY) begin
                par_bit <= s_in;
                bit_idx <= '0;
            end
            if (state == S_DATA) begin
                shift[bit_idx] <= s_in;
                if (bit_idx != LAST_IDX) bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Holding register: a load always wins over an ack in the same edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            data_out   <= shift;
            parity_err <= even_parity(shift) != par_bit;
            frame_err  <= s_in != IDLE_LVL;
            data_valid <= 1'b1;
            overrun    <= data_valid && !data_ack;
        end else if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rx_frame_receiver.sv
// Bench for rx_frame_receiver: frame-level stimulus for a START_SIG=0 and a
// START_SIG=1 instance, checked every cycle against a word-level model.
module tb_rx_frame_receiver;

    logic       clk = 1'b0;
    logic       rstN;
    logic       s_in0, s_in1, data_ack;
    logic [6:0] data_out0, data_out1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1;
    logic       ovr0, ovr1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Schedule for the next edge, written by the stimulus.
    logic       sch_busy = 1'b0, sch_load = 1'b0;
    logic [6:0] sch_data = '0;
    logic       sch_perr = 1'b0, sch_ferr = 1'b0;

    // Word-level model of what the consumer sees.
    logic [6:0] m_data = '0;
    logic       m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;
    logic       m_ovr = 1'b0, m_busy = 1'b0;

    always #5 clk = ~clk;

    rx_frame_receiver #(.START_SIG(1'b0)) u_dut0 (
        .clk(clk), .rstN(rstN), .s_in(s_in0), .data_ack(data_ack),
        .data_out(data_out0), .data_valid(valid0), .parity_err(perr0),
        .frame_err(ferr0), .overrun(ovr0), .busy(busy0)
    );

    rx_frame_receiver #(.START_SIG(1'b1)) u_dut1 (
        .clk(clk), .rstN(rstN), .s_in(s_in1), .data_ack(data_ack),
        .data_out(data_out1), .data_valid(valid1), .parity_err(perr1),
        .frame_err(ferr1), .overrun(ovr1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_data <= '0; m_valid <= 1'b0; m_perr <= 1'b0;
            m_ferr <= 1'b0; m_ovr <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_busy <= sch_busy;
            if (sch_load) begin
                m_data  <= sch_data;
                m_perr  <= sch_perr;
                m_ferr  <= sch_ferr;
                m_valid <= 1'b1;
                m_ovr   <= m_valid && !data_ack;
            end else if (data_ack && m_valid) begin
                m_valid <= 1'b0;
                m_ovr   <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("dut0 data_out", 32'(data_out0), 32'(m_data));
            check("dut0 data_valid", 32'(valid0), 32'(m_valid));
            check("dut0 parity_err", 32'(perr0), 32'(m_perr));
            check("dut0 frame_err", 32'(ferr0), 32'(m_ferr));
            check("dut0 overrun", 32'(ovr0), 32'(m_ovr));
            check("dut0 busy", 32'(busy0), 32'(m_busy));
            check("dut1 data_out", 32'(data_out1), 32'(m_data));
            check("dut1 data_valid", 32'(valid1), 32'(m_valid));
            check("dut1 parity_err", 32'(perr1), 32'(m_perr));
            check("dut1 frame_err", 32'(ferr1), 32'(m_ferr));
            check("dut1 overrun", 32'(ovr1), 32'(m_ovr));
            check("dut1 busy", 32'(busy1), 32'(m_busy));
        end
    end

    // One line bit: b0 is the START_SIG=0 line level, b1 the START_SIG=1 level.
    task automatic send_edge(input logic b0, input logic b1, input logic ack,
                             input logic busy_after, input logic load,
                             input logic [6:0] d, input logic pe, input logic fe);
        @(negedge clk);
        #1;
        s_in0 = b0; s_in1 = b1; data_ack = ack;
        sch_busy = busy_after; sch_load = load;
        sch_data = d; sch_perr = pe; sch_ferr = fe;
    endtask

    function automatic logic rnd_ack(input bit rnd);
        return rnd && ($urandom_range(0, 2) == 0);
    endfunction

    task automatic send_idle(input logic ack);
        send_edge(1'b1, 1'b0, ack, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Start through stop; data and parity bits carry the same level on both lines.
    task automatic send_frame(input logic [6:0] d, input bit pflip, input bit sbad,
                              input logic ack9, input bit rnd);
        logic p;
        logic stop0;
        p = (^d) ^ pflip;
        send_edge(1'b0, 1'b1, rnd_ack(rnd), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        send_edge(p, p, rnd_ack(rnd), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            send_edge(d[i], d[i], rnd_ack(rnd), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        stop0 = sbad ? 1'b0 : 1'b1;
        send_edge(stop0, ~stop0, ack9 | rnd_ack(rnd), logic'(sbad), 1'b1, d, pflip, sbad);
    endtask

    task automatic send_hold(input int k, input bit rnd);
        for (int i = 0; i < k; i++)
            send_edge(1'b0, 1'b1, rnd_ack(rnd), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [6:0] d, input logic v,
                              input logic pe, input logic fe, input logic ov, input logic b);
        check({tag, " data_out"}, 32'(data_out0), 32'(d));
        check({tag, " data_out1"}, 32'(data_out1), 32'(d));
        check({tag, " data_valid"}, 32'(valid0), 32'(v));
        check({tag, " parity_err"}, 32'(perr0), 32'(pe));
        check({tag, " frame_err"}, 32'(ferr0), 32'(fe));
        check({tag, " overrun"}, 32'(ovr0), 32'(ov));
        check({tag, " busy"}, 32'(busy0), 32'(b));
        check({tag, " busy1"}, 32'(busy1), 32'(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; s_in0 = 1'b1; s_in1 = 1'b0; data_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 7'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstN = 1'b1;
        started = 1'b1;
        send_idle(1'b0);

        // Clean frame 0x55: valid right after E9, receiver already idle.
        send_frame(7'h55, 0, 0, 1'b0, 0);
        settle();
        expect_out("f55", 7'h55, 1, 0, 0, 0, 0);
        send_idle(1'b1);

        // 0x13 with wrong parity bit still delivered, flagged.
        send_frame(7'h13, 1, 0, 1'b0, 0);
        settle();
        expect_out("f13", 7'h13, 1, 1, 0, 0, 0);
        send_idle(1'b1);

        // 0x2A with bad stop and a stuck line: held busy, no second word.
        send_frame(7'h2A, 0, 1, 1'b0, 0);
        settle();
        expect_out("f2a", 7'h2A, 1, 0, 1, 0, 1);
        send_hold(5, 0);
        settle();
        expect_out("f2a_stuck", 7'h2A, 1, 0, 1, 0, 1);
        send_idle(1'b1);
        settle();
        expect_out("f2a_idle", 7'h2A, 0, 0, 1, 0, 0);

        // Back-to-back without ack, then with ack on the second load edge.
        send_frame(7'h01, 0, 0, 1'b0, 0);
        send_frame(7'h7F, 0, 0, 1'b0, 0);
        settle();
        expect_out("ovr", 7'h7F, 1, 0, 0, 1, 0);
        send_idle(1'b1);
        settle();
        expect_out("ovr_ack", 7'h7F, 0, 0, 0, 0, 0);
        send_frame(7'h01, 0, 0, 1'b0, 0);
        send_frame(7'h7F, 0, 0, 1'b1, 0);
        settle();
        expect_out("ack_on_load", 7'h7F, 1, 0, 0, 0, 0);
        send_idle(1'b1);

        // Reset asserted during E5 of a frame, then a clean 0x40.
        send_edge(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        send_edge(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            send_edge(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        settle();
        #2;
        rstN = 1'b0;
        s_in0 = 1'b1; s_in1 = 1'b0; sch_busy = 1'b0; sch_load = 1'b0;
        #1;
        expect_out("mid_reset", 7'h00, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        send_frame(7'h40, 0, 0, 1'b0, 0);
        settle();
        expect_out("f40", 7'h40, 1, 0, 0, 0, 0);
        send_idle(1'b1);

        // Randomised frames, errors, gaps and acks.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] d;
            bit pflip, sbad;
            d     = 7'($urandom);
            pflip = ($urandom_range(0, 3) == 0);
            sbad  = ($urandom_range(0, 5) == 0);
            send_frame(d, pflip, sbad, 1'b0, 1);
            if (sbad) begin
                send_hold(int'($urandom_range(0, 4)), 1);
                send_idle(rnd_ack(1));
            end
            repeat ($urandom_range(0, 2)) send_idle(rnd_ack(1));
        end
        send_idle(1'b0);
        send_idle(1'b0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_receiver.md
Name: rx_frame_receiver

Overview:
Serial receiver for the team's 7-bit UART-style link. It runs on the same clk as the transmitter and takes one line bit per clock. It deframes start, parity, 7 data bits (LSB first) and stop. It presents the byte on a valid/ack holding register with parity, framing and overrun status. It sits at the far end of the serial line, opposite the existing transmitter.

Parameters:
START_SIG, 0, line level of the start bit; idle and stop level is ~START_SIG.

Ports:
clk  input  1  system clock; one line bit per rising edge
rstN  input  1  asynchronous, active-low reset
s_in  input  1  serial line, synchronous to clk
data_ack  input  1  consumer acknowledge; clears data_valid
data_out  output  7  last received data word
data_valid  output  1  level; high while data_out holds an unacknowledged word
parity_err  output  1  parity mismatch on the word in data_out
frame_err  output  1  stop bit wrong on the word in data_out
overrun  output  1  a word completed while the previous one was still unacknowledged
busy  output  1  high in any state except S_IDLE

Behaviour:
- Reset: rstN is asynchronous and active-low; the clock is clk. While rstN=0: state=S_IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, bit index=0, shift register=0.
- Frame on line, one bit per clk: start (START_SIG), parity, d0..d6, stop (~START_SIG). Parity is even: parity bit = XOR of d0..d6.
- FSM, all transitions on rising clk:
  - S_IDLE: if s_in==START_SIG, go to S_PARITY. This edge is E0.
  - S_PARITY (E1): capture s_in as the received parity bit; clear bit index; go to S_DATA.
  - S_DATA (E2..E8): shift[index] <= s_in; index++; after index 6, go to S_STOP.
  - S_STOP (E9): load the result register (below).
    - If s_in == ~START_SIG, go to S_IDLE.
    - Else go to S_WAIT_IDLE.
  - S_WAIT_IDLE: stay until s_in == ~START_SIG, then go to S_IDLE. This prevents retriggering on a stuck line.
- Result load at E9, all in the same edge:
  - data_out <= shift with d6 taken from the E8 capture.
  - parity_err <= (XOR of the 7 data bits) != captured parity.
  - frame_err <= (s_in != ~START_SIG).
  - data_valid <= 1.
- Latency: data_valid rises at E9, 9 clocks after the start-bit sample. It is visible to the consumer in the cycle after E9.
- Data with parity or framing errors is still delivered; the flags describe it.
- Ack:
  - data_ack=1 at an edge with data_valid=1 and no load: clears data_valid and overrun. data_out and the error flags hold.
  - data_ack while data_valid=0: ignored.
- Overrun:
  - Load with data_valid=1 and data_ack=0: new word overwrites data_out and flags; overrun <= 1 (sticky until an ack).
  - Load with data_ack=1 in the same edge: new word loaded, data_valid stays 1, overrun <= 0.
- Back-to-back frames: a start bit sampled in S_IDLE at E10 is accepted; the minimum frame period is 10 clocks.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values immediately. A partial frame after reset deassertion is ignored unless s_in equals START_SIG while in S_IDLE.
- Width: bit index is 3 bits, counting 0..6 only; no wrap beyond 6.

Decomposition:
- Shared package holds:
  - FSM state encodings S_IDLE, S_PARITY, S_DATA, S_STOP, S_WAIT_IDLE (3-bit);
  - DATA_BITS=7 and FRAME_BITS=10;
  - the even-parity function, shared with the transmitter.
- No sub-module is needed. The output holding register with valid/ack/overrun may optionally be split out as rx_hold_reg.

Test Plan:
- Loopback with the transmitter, START_SIG=0, data_in=7'h55 (line 0,0,1,0,1,0,1,0,1,1) -> data_valid at E9, data_out=7'h55, parity_err=0, frame_err=0.
- Driven frame 7'h13 with parity bit 0 (correct is 1) -> data_out=7'h13, parity_err=1, frame_err=0.
- Frame 7'h2A with stop bit 0 and the line held 0 for 5 more clocks -> frame_err=1; FSM in S_WAIT_IDLE, busy=1, until line=1; no spurious second word.
- Two frames 7'h01 then 7'h7F back-to-back, no ack -> second load gives data_out=7'h7F, overrun=1. Repeat with data_ack asserted on the second load edge -> overrun=0, data_valid=1.
- rstN pulsed low at E5 of a frame -> all outputs 0 immediately. The next full frame 7'h40 is received correctly.
- START_SIG=1 build, data 7'h00 -> data_out=7'h00, parity_err=0, busy low 1 clock after E9.
